// File: rtl/dm_access_ctrl.sv
// MEM-stage load/store controller on a req/ack bus: done 2 cycles after acceptance plus 1 per wait cycle, pipeline stalled until then.
// Define DM_MISALIGN_CHECK_EN to reject misaligned half/word accesses with err instead of issuing them.
module dm_access_ctrl #(
   parameter int TIMEOUT_CYC = 16,
   parameter int CNT_W       = 5
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_req_valid,
   input  logic [2:0]  i_req_op,
   input  logic [31:0] i_req_addr,
   input  logic [31:0] i_req_wdata,
   output logic        o_stall,
   output logic [31:0] o_rdata,
   output logic        o_done,
   output logic        o_err,
   output logic        o_mem_req,
   output logic        o_mem_we,
   output logic [31:0] o_mem_addr,
   output logic [3:0]  o_mem_byteen,
   output logic [31:0] o_mem_wdata,
   input  logic [31:0] i_mem_rdata,
   input  logic        i_mem_ack
);

   localparam logic [2:0] OP_LW  = 3'b000;
   localparam logic [2:0] OP_LH  = 3'b001;
   localparam logic [2:0] OP_LHU = 3'b010;
   localparam logic [2:0] OP_LB  = 3'b011;
   localparam logic [2:0] OP_LBU = 3'b100;
   localparam logic [2:0] OP_SW  = 3'b101;
   localparam logic [2:0] OP_SH  = 3'b110;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

   state_t            r_state;
   state_t            w_next;
   logic [2:0]        r_op;
   logic [31:0]       r_addr;
   logic [31:0]       r_wdata;
   logic [31:0]       r_rdata;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_err;
   logic              r_done_prev;

   logic              w_issue;
   logic              w_capture;
   logic              w_err_set;
   logic              w_misalign;
   logic              w_in_req;
   logic [1:0]        w_size;
   logic [3:0]        w_byteen;
   logic [31:0]       w_wdata_lane;
   logic [31:0]       w_rd_shift;
   logic [7:0]        w_rd_byte;
   logic [15:0]       w_rd_half;
   logic [31:0]       w_load_ext;

   function automatic logic [1:0] f_size(input logic [2:0] op);
      logic [1:0] sz;
      sz = SZ_BYTE;
      if (op == OP_LW || op == OP_SW)
         sz = SZ_WORD;
      else if (op == OP_LH || op == OP_LHU || op == OP_SH)
         sz = SZ_HALF;
      return sz;
   endfunction

`ifdef DM_MISALIGN_CHECK_EN
   always_comb begin
      w_misalign = 1'b0;
      if (f_size(i_req_op) == SZ_HALF)
         w_misalign = i_req_addr[0];
      else if (f_size(i_req_op) == SZ_WORD)
         w_misalign = (i_req_addr[1:0] != 2'b00);
   end
`else
   assign w_misalign = 1'b0;
`endif

   // The pipeline keeps presenting a finished instruction for one cycle after done; that cycle must not re-issue.
   always_comb begin
      w_next    = r_state;
      w_issue   = 1'b0;
      w_capture = 1'b0;
      w_err_set = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_req_valid && !r_done_prev) begin
               if (w_misalign) begin
                  w_err_set = 1'b1;
               end else begin
                  w_issue = 1'b1;
                  w_next  = S_REQ;
               end
            end
         end
         S_REQ: begin
            if (i_mem_ack) begin
               w_capture = 1'b1;
               w_next    = S_RESP;
            end else if (r_cnt == CNT_LAST) begin
               w_err_set = 1'b1;
               w_next    = S_IDLE;
            end
         end
         S_RESP: begin
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state     <= S_IDLE;
         r_op        <= '0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_rdata     <= '0;
         r_cnt       <= '0;
         r_err       <= 1'b0;
         r_done_prev <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_err       <= w_err_set;
         r_done_prev <= (r_state == S_RESP);
         if (w_issue) begin
            r_op    <= i_req_op;
            r_addr  <= i_req_addr;
            r_wdata <= i_req_wdata;
         end
         if (w_capture)
            r_rdata <= w_load_ext;
         if (r_state == S_REQ && w_next == S_REQ)
            r_cnt <= r_cnt + 1'b1;
         else
            r_cnt <= '0;
      end
   end

   assign w_size = f_size(r_op);

   always_comb begin
      w_byteen     = 4'b0000;
      w_wdata_lane = r_wdata;
      case (w_size)
         SZ_WORD: begin
            w_byteen     = 4'b1111;
            w_wdata_lane = r_wdata;
         end
         SZ_HALF: begin
            w_byteen     = r_addr[1] ? 4'b1100 : 4'b0011;
            w_wdata_lane = {2{r_wdata[15:0]}};
         end
         default: begin
            w_byteen     = 4'b0001 << r_addr[1:0];
            w_wdata_lane = {4{r_wdata[7:0]}};
         end
      endcase
   end

   assign w_rd_shift = i_mem_rdata >> {r_addr[1:0], 3'b000};
   assign w_rd_byte  = w_rd_shift[7:0];
   assign w_rd_half  = r_addr[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];

   always_comb begin
      w_load_ext = '0;
      case (r_op)
         OP_LW:   w_load_ext = i_mem_rdata;
         OP_LH:   w_load_ext = {{16{w_rd_half[15]}}, w_rd_half};
         OP_LHU:  w_load_ext = {16'h0000, w_rd_half};
         OP_LB:   w_load_ext = {{24{w_rd_byte[7]}}, w_rd_byte};
         OP_LBU:  w_load_ext = {24'h000000, w_rd_byte};
         default: w_load_ext = '0;
      endcase
   end

   // Bus outputs are held at zero outside REQ so reset clears them without waiting for a clock.
   assign w_in_req     = (r_state == S_REQ);
   assign o_mem_req    = w_in_req;
   assign o_mem_we     = w_in_req & r_op[2] & (r_op != OP_LBU);
   assign o_mem_addr   = w_in_req ? {r_addr[31:2], 2'b00} : '0;
   assign o_mem_byteen = w_in_req ? w_byteen : 4'b0000;
   assign o_mem_wdata  = w_in_req ? w_wdata_lane : '0;

   assign o_done  = (r_state == S_RESP);
   assign o_rdata = o_done ? r_rdata : '0;
   assign o_err   = r_err;
   assign o_stall = i_reset & (w_in_req | ((r_state == S_IDLE) & i_req_valid & ~r_done_prev));

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl: table of load/store transactions plus hand sequences for timeout, reset, double issue and misalignment.
module tb_dm_access_ctrl;

   logic        clk;
   logic        i_reset;
   logic        i_req_valid;
   logic [2:0]  i_req_op;
   logic [31:0] i_req_addr;
   logic [31:0] i_req_wdata;
   logic        o_stall;
   logic [31:0] o_rdata;
   logic        o_done;
   logic        o_err;
   logic        o_mem_req;
   logic        o_mem_we;
   logic [31:0] o_mem_addr;
   logic [3:0]  o_mem_byteen;
   logic [31:0] o_mem_wdata;
   logic [31:0] i_mem_rdata;
   logic        i_mem_ack;

   int n_chk  = 0;
   int n_pass = 0;

   dm_access_ctrl #(.TIMEOUT_CYC(16), .CNT_W(5)) dut (
      .i_clk        (clk),
      .i_reset      (i_reset),
      .i_req_valid  (i_req_valid),
      .i_req_op     (i_req_op),
      .i_req_addr   (i_req_addr),
      .i_req_wdata  (i_req_wdata),
      .o_stall      (o_stall),
      .o_rdata      (o_rdata),
      .o_done       (o_done),
      .o_err        (o_err),
      .o_mem_req    (o_mem_req),
      .o_mem_we     (o_mem_we),
      .o_mem_addr   (o_mem_addr),
      .o_mem_byteen (o_mem_byteen),
      .o_mem_wdata  (o_mem_wdata),
      .i_mem_rdata  (i_mem_rdata),
      .i_mem_ack    (i_mem_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp)
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      else
         n_pass++;
   endtask

   typedef struct {
      logic [2:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] mrd;
      int          waits;
      logic [3:0]  be;
      logic        we;
      logic [31:0] maddr;
      logic [31:0] mwd;
      logic [31:0] rd;
   } vec_t;

   vec_t vt[12];

   initial begin
      int cyc;
      int stall_n;
      int reqc;
      logic req_ok;
      logic saw_done;

      vt[0]  = '{3'd5, 32'h0000_1004, 32'hDEAD_BEEF, 32'h0000_0000, 0, 4'b1111, 1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 32'h0000_0000};
      vt[1]  = '{3'd7, 32'h0000_2003, 32'h0000_00A5, 32'h0000_0000, 3, 4'b1000, 1'b1, 32'h0000_2000, 32'hA5A5_A5A5, 32'h0000_0000};
      vt[2]  = '{3'd3, 32'h0000_3002, 32'h0000_0000, 32'h1280_3456, 1, 4'b0100, 1'b0, 32'h0000_3000, 32'h0000_0000, 32'hFFFF_FF80};
      vt[3]  = '{3'd4, 32'h0000_3002, 32'h0000_0000, 32'h1280_3456, 0, 4'b0100, 1'b0, 32'h0000_3000, 32'h0000_0000, 32'h0000_0080};
      vt[4]  = '{3'd1, 32'h0000_3002, 32'h0000_0000, 32'h8001_0000, 2, 4'b1100, 1'b0, 32'h0000_3000, 32'h0000_0000, 32'hFFFF_8001};
      vt[5]  = '{3'd2, 32'h0000_3002, 32'h0000_0000, 32'h8001_0000, 0, 4'b1100, 1'b0, 32'h0000_3000, 32'h0000_0000, 32'h0000_8001};
      vt[6]  = '{3'd0, 32'h0000_4000, 32'h0000_0000, 32'hCAFE_F00D, 2, 4'b1111, 1'b0, 32'h0000_4000, 32'h0000_0000, 32'hCAFE_F00D};
      vt[7]  = '{3'd6, 32'h0000_5002, 32'h1234_BEEF, 32'h0000_0000, 1, 4'b1100, 1'b1, 32'h0000_5000, 32'hBEEF_BEEF, 32'h0000_0000};
      vt[8]  = '{3'd3, 32'h0000_6000, 32'h0000_0000, 32'h0000_007F, 0, 4'b0001, 1'b0, 32'h0000_6000, 32'h0000_0000, 32'h0000_007F};
      vt[9]  = '{3'd1, 32'h0000_6000, 32'h0000_0000, 32'h0000_F00F, 1, 4'b0011, 1'b0, 32'h0000_6000, 32'h0000_0000, 32'hFFFF_F00F};
      vt[10] = '{3'd7, 32'h0000_6001, 32'hFFFF_FF3C, 32'h0000_0000, 0, 4'b0010, 1'b1, 32'h0000_6000, 32'h3C3C_3C3C, 32'h0000_0000};
      vt[11] = '{3'd4, 32'h0000_6003, 32'h0000_0000, 32'h9A00_0000, 0, 4'b1000, 1'b0, 32'h0000_6000, 32'h0000_0000, 32'h0000_009A};

      i_reset     = 1'b0;
      i_req_valid = 1'b1;
      i_req_op    = 3'd5;
      i_req_addr  = 32'h0000_1004;
      i_req_wdata = 32'h1111_1111;
      i_mem_rdata = 32'h0;
      i_mem_ack   = 1'b0;
      #12;
      chk("rst_stall",   32'(o_stall),   32'h0);
      chk("rst_mem_req", 32'(o_mem_req), 32'h0);
      chk("rst_done",    32'(o_done),    32'h0);
      chk("rst_err",     32'(o_err),     32'h0);
      chk("rst_byteen",  32'(o_mem_byteen), 32'h0);
      chk("rst_addr",    o_mem_addr,     32'h0);
      chk("rst_rdata",   o_rdata,        32'h0);
      @(negedge clk);
      i_reset     = 1'b1;
      i_req_valid = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         i_req_valid = 1'b1;
         i_req_op    = vt[i].op;
         i_req_addr  = vt[i].addr;
         i_req_wdata = vt[i].wdata;
         #1;
         stall_n = int'(o_stall);
         @(negedge clk);
         i_req_valid = 1'b0;
         i_req_op    = 3'd5;
         i_req_addr  = 32'hFFFF_FFFF;
         i_req_wdata = 32'hFFFF_FFFF;
         #1;
         chk($sformatf("v%0d_mem_req", i), 32'(o_mem_req),    32'h1);
         chk($sformatf("v%0d_addr", i),    o_mem_addr,        vt[i].maddr);
         chk($sformatf("v%0d_byteen", i),  32'(o_mem_byteen), 32'(vt[i].be));
         chk($sformatf("v%0d_we", i),      32'(o_mem_we),     32'(vt[i].we));
         if (vt[i].we)
            chk($sformatf("v%0d_wdata", i), o_mem_wdata, vt[i].mwd);
         cyc    = 1;
         req_ok = 1'b1;
         for (int w = 0; w < vt[i].waits; w++) begin
            stall_n += int'(o_stall);
            req_ok  &= o_mem_req;
            @(negedge clk);
            cyc++;
         end
         stall_n += int'(o_stall);
         req_ok  &= o_mem_req;
         i_mem_ack   = 1'b1;
         i_mem_rdata = vt[i].mrd;
         @(negedge clk);
         cyc++;
         i_mem_ack   = 1'b0;
         i_mem_rdata = 32'h5A5A_5A5A;
         while (!o_done && cyc < 40) begin
            stall_n += int'(o_stall);
            @(negedge clk);
            cyc++;
         end
         chk($sformatf("v%0d_latency", i),   32'(cyc),        32'(vt[i].waits + 2));
         chk($sformatf("v%0d_done", i),      32'(o_done),     32'h1);
         chk($sformatf("v%0d_rdata", i),     o_rdata,         vt[i].rd);
         chk($sformatf("v%0d_stall_cyc", i), 32'(stall_n),    32'(vt[i].waits + 2));
         chk($sformatf("v%0d_req_held", i),  32'(req_ok),     32'h1);
         chk($sformatf("v%0d_req_drop", i),  32'(o_mem_req),  32'h0);
         chk($sformatf("v%0d_done_stall", i), 32'(o_stall),   32'h0);
         @(negedge clk);
         chk($sformatf("v%0d_done_pulse", i), 32'(o_done),    32'h0);
      end

      // Timeout: no ack ever arrives.
      @(negedge clk);
      i_req_valid = 1'b1;
      i_req_op    = 3'd0;
      i_req_addr  = 32'h0000_7000;
      @(negedge clk);
      i_req_valid = 1'b0;
      reqc     = 0;
      saw_done = 1'b0;
      cyc      = 0;
      while (!o_err && cyc < 40) begin
         reqc     += int'(o_mem_req);
         saw_done |= o_done;
         @(negedge clk);
         cyc++;
      end
      chk("to_req_cycles", 32'(reqc),                32'd16);
      chk("to_err",        32'(o_err),               32'h1);
      chk("to_mem_req",    32'(o_mem_req),           32'h0);
      chk("to_stall",      32'(o_stall),             32'h0);
      chk("to_no_done",    32'(saw_done | o_done),   32'h0);
      @(negedge clk);
      chk("to_err_pulse",  32'(o_err),               32'h0);

      // Held request across done must not re-issue.
      @(negedge clk);
      i_req_valid = 1'b1;
      i_req_op    = 3'd5;
      i_req_addr  = 32'h0000_9008;
      i_req_wdata = 32'h1122_3344;
      @(negedge clk);
      i_mem_ack = 1'b1;
      @(negedge clk);
      i_mem_ack = 1'b0;
      chk("dbl_done",  32'(o_done),    32'h1);
      @(negedge clk);
      chk("dbl_stall", 32'(o_stall),   32'h0);
      chk("dbl_req",   32'(o_mem_req), 32'h0);
      i_req_valid = 1'b0;
      @(negedge clk);
      chk("dbl_req2",  32'(o_mem_req), 32'h0);

      // Ack while idle is ignored.
      i_mem_ack   = 1'b1;
      i_mem_rdata = 32'h1234_5678;
      @(negedge clk);
      i_mem_ack = 1'b0;
      chk("idle_ack_done", 32'(o_done),    32'h0);
      chk("idle_ack_req",  32'(o_mem_req), 32'h0);

      // Reset in the middle of REQ.
      @(negedge clk);
      i_req_valid = 1'b1;
      i_req_op    = 3'd7;
      i_req_addr  = 32'h0000_A001;
      i_req_wdata = 32'h0000_0077;
      @(negedge clk);
      chk("mr_pre_req", 32'(o_mem_req), 32'h1);
      #2;
      i_reset = 1'b0;
      #1;
      chk("mr_mem_req", 32'(o_mem_req),    32'h0);
      chk("mr_stall",   32'(o_stall),      32'h0);
      chk("mr_byteen",  32'(o_mem_byteen), 32'h0);
      chk("mr_wdata",   o_mem_wdata,       32'h0);
      chk("mr_we",      32'(o_mem_we),     32'h0);
      chk("mr_addr",    o_mem_addr,        32'h0);
      @(negedge clk);
      i_req_valid = 1'b0;
      i_reset     = 1'b1;
      @(negedge clk);
      chk("mr_no_done", 32'(o_done),    32'h0);
      chk("mr_no_err",  32'(o_err),     32'h0);
      chk("mr_idle",    32'(o_mem_req), 32'h0);

      // Misaligned word load.
      @(negedge clk);
      i_req_valid = 1'b1;
      i_req_op    = 3'd0;
      i_req_addr  = 32'h0000_B002;
      @(negedge clk);
      i_req_valid = 1'b0;
`ifdef DM_MISALIGN_CHECK_EN
      chk("ma_err",     32'(o_err),     32'h1);
      chk("ma_req",     32'(o_mem_req), 32'h0);
      @(negedge clk);
      chk("ma_err_off", 32'(o_err),     32'h0);
      chk("ma_req2",    32'(o_mem_req), 32'h0);
`else
      chk("ma_req",    32'(o_mem_req),    32'h1);
      chk("ma_addr",   o_mem_addr,        32'h0000_B000);
      chk("ma_byteen", 32'(o_mem_byteen), 32'hF);
      i_mem_ack   = 1'b1;
      i_mem_rdata = 32'h0BAD_F00D;
      @(negedge clk);
      i_mem_ack = 1'b0;
      chk("ma_done",   32'(o_done),       32'h1);
      chk("ma_rdata",  o_rdata,           32'h0BAD_F00D);
`endif

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
